multicycle_control_fsm: RTL and testbench

- Multicycle control unit for the RV32I-subset datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath control line.
- Generates the PC-select line (pc_src) that feeds the 32-bit PC 2:1 mux, resolving beq/bne from the ALU zero flag.
- Stretches FETCH and MEM with memory wait states, flags illegal instructions, and counts retired instructions.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/branch_resolve.sv | 22 ++
 rtl/multicycle_control_fsm.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit:
// FSM states, opcodes, ALU operation codes and branch funct3 values.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_ILLEGAL = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition resolution: taken decision for beq/bne and a flag for
// funct3 values that are not a supported branch.
module branch_resolve
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       taken,
  output logic       bad_funct3
);

  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath control lines, flags illegal instructions and counts retirements.
//
// state   | meaning
// FETCH   | read instruction, wait for mem_ready, load IR and PC+4
// DECODE  | latch opcode/funct3, check legality
// EXEC    | ALU operation; branches resolve and retire here
// MEM     | load/store access, stretched by mem_ready
// WB      | register file write, retire
// ILLEGAL | illegal instruction seen, held until reset
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int ST_W        = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   ir_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic                   alu_src,
  output logic [1:0]             alu_op,
  output logic                   mem_to_reg,
  output logic                   illegal,
  output logic [ST_W-1:0]        state,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  state_t                 r_state;
  state_t                 w_next;
  logic [6:0]             r_opcode;
  logic [2:0]             r_funct3;
  logic [COUNT_WIDTH-1:0] r_retired_count;

  logic       w_retire;
  logic [2:0] w_br_funct3;
  logic       w_br_taken;
  logic       w_br_bad;

  // One resolver serves both phases: live funct3 for the DECODE legality
  // check, the latched copy once the instruction register may have moved on.
  assign w_br_funct3 = (r_state == S_DECODE) ? funct3 : r_funct3;

  branch_resolve u_branch_resolve (
    .funct3     (w_br_funct3),
    .zero       (zero),
    .taken      (w_br_taken),
    .bad_funct3 (w_br_bad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_FETCH;
      r_opcode        <= 7'd0;
      r_funct3        <= 3'd0;
      r_retired_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        r_funct3 <= funct3;
      end
      if (w_retire) begin
        r_retired_count <= r_retired_count + COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!is_known_op(opcode) || ((opcode == OP_BRANCH) && w_br_bad)) begin
          w_next = S_ILLEGAL;
        end else begin
          w_next = S_EXEC;
        end
      end

      S_EXEC: begin
        case (r_opcode)
          OP_R: begin
            alu_op = ALU_FUNCT;
            w_next = S_WB;
          end
          OP_I: begin
            alu_op  = ALU_FUNCT;
            alu_src = 1'b1;
            w_next  = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
            w_next  = S_MEM;
          end
          OP_BRANCH: begin
            alu_op   = ALU_SUB;
            pc_write = w_br_taken;
            pc_src   = w_br_taken;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        case (r_opcode)
          OP_LOAD: begin
            mem_read = 1'b1;
            if (mem_ready) w_next = S_WB;
          end
          OP_STORE: begin
            mem_write = 1'b1;
            if (mem_ready) begin
              w_retire = 1'b1;
              w_next   = S_FETCH;
            end
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_opcode == OP_LOAD);
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end

      S_ILLEGAL: begin
        illegal = 1'b1;
      end

      default: w_next = S_FETCH;
    endcase
  end

  assign state         = ST_W'(r_state);
  assign retired_count = r_retired_count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle
// plan from the instruction-level rules, then driven with randomized noise.
module tb_multicycle_control_fsm;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_I      = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
  logic        alu_src, mem_to_reg, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired_count;

  multicycle_control_fsm #(.COUNT_WIDTH(32), .ST_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .mem_to_reg    (mem_to_reg),
    .illegal       (illegal),
    .state         (state),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [10:0] ctl;
    logic        rdy;
    logic        z;
    logic        dec;
    logic        ret;
  } step_t;

  step_t       plan[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_count;

  function automatic logic [10:0] c(input logic pcw, pcs, irw, mr, mw, rw, as,
                                    input logic [1:0] ao, input logic m2r, ill);
    return {pcw, pcs, irw, mr, mw, rw, as, ao, m2r, ill};
  endfunction

  function automatic step_t mk(input logic [2:0] st, input logic [10:0] ctl,
                               input logic rdy, z, dec, ret);
    step_t s;
    s.st = st; s.ctl = ctl; s.rdy = rdy; s.z = z; s.dec = dec; s.ret = ret;
    return s;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected cycle plan for one instruction, straight from the per-phase rules.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input int fw,
                       input int mw, input logic z, input int ill_cycles);
    logic legal, taken;
    plan.delete();
    for (int i = 0; i < fw; i++) plan.push_back(mk(3'd0, c(0,0,0,1,0,0,0,2'b00,0,0), 1'b0, rbit(), 0, 0));
    plan.push_back(mk(3'd0, c(1,0,1,1,0,0,0,2'b00,0,0), 1'b1, rbit(), 0, 0));
    plan.push_back(mk(3'd1, c(0,0,0,0,0,0,0,2'b00,0,0), rbit(), rbit(), 1, 0));
    legal = (op == T_R) || (op == T_I) || (op == T_LOAD) || (op == T_STORE) ||
            ((op == T_BRANCH) && (f3 <= 3'd1));
    if (!legal) begin
      for (int i = 0; i < ill_cycles; i++)
        plan.push_back(mk(3'd5, c(0,0,0,0,0,0,0,2'b00,0,1), rbit(), rbit(), 0, 0));
      return;
    end
    case (op)
      T_R:     plan.push_back(mk(3'd2, c(0,0,0,0,0,0,0,2'b10,0,0), rbit(), z, 0, 0));
      T_I:     plan.push_back(mk(3'd2, c(0,0,0,0,0,0,1,2'b10,0,0), rbit(), z, 0, 0));
      T_BRANCH: begin
        taken = (f3 == 3'd0) ? z : !z;
        plan.push_back(mk(3'd2, c(taken,taken,0,0,0,0,0,2'b01,0,0), rbit(), z, 0, 1));
      end
      default: plan.push_back(mk(3'd2, c(0,0,0,0,0,0,1,2'b00,0,0), rbit(), z, 0, 0));
    endcase
    if (op == T_LOAD) begin
      for (int i = 0; i < mw; i++) plan.push_back(mk(3'd3, c(0,0,0,1,0,0,0,2'b00,0,0), 1'b0, rbit(), 0, 0));
      plan.push_back(mk(3'd3, c(0,0,0,1,0,0,0,2'b00,0,0), 1'b1, rbit(), 0, 0));
      plan.push_back(mk(3'd4, c(0,0,0,0,0,1,0,2'b00,1,0), rbit(), rbit(), 0, 1));
    end else if (op == T_STORE) begin
      for (int i = 0; i < mw; i++) plan.push_back(mk(3'd3, c(0,0,0,0,1,0,0,2'b00,0,0), 1'b0, rbit(), 0, 0));
      plan.push_back(mk(3'd3, c(0,0,0,0,1,0,0,2'b00,0,0), 1'b1, rbit(), 0, 1));
    end else if (op != T_BRANCH) begin
      plan.push_back(mk(3'd4, c(0,0,0,0,0,1,0,2'b00,0,0), rbit(), rbit(), 0, 1));
    end
  endtask

  task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input int limit);
    for (int i = 0; i < plan.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = plan[i].rdy;
      zero      = (plan[i].st == 3'd2) ? plan[i].z : rbit();
      if (plan[i].dec) begin
        opcode = op;
        funct3 = f3;
      end else begin
        opcode = 7'($urandom);
        funct3 = 3'($urandom);
      end
      #1;
      chk($sformatf("%s[%0d].state", name, i), 32'(state), 32'(plan[i].st));
      chk($sformatf("%s[%0d].ctl", name, i),
          32'({pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
               alu_src, alu_op, mem_to_reg, illegal}), 32'(plan[i].ctl));
      chk($sformatf("%s[%0d].count", name, i), retired_count, exp_count);
      if (plan[i].ret) exp_count = exp_count + 32'd1;
    end
  endtask

  task automatic do_reset(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset     = 1'b1;
      mem_ready = rbit();
      zero      = rbit();
      opcode    = 7'($urandom);
      funct3    = 3'($urandom);
    end
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    exp_count = 32'd0;
    chk({name, ".state"}, 32'(state), 32'd0);
    chk({name, ".ctl"},
        32'({pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
             alu_src, alu_op, mem_to_reg, illegal}), 32'(c(0,0,0,1,0,0,0,2'b00,0,0)));
    chk({name, ".count"}, retired_count, 32'd0);
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         k;
    reset = 1'b1; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    exp_count = 32'd0;

    do_reset("por", 2);

    build(T_R, 3'd0, 0, 0, 1'b0, 0);           run("radd", T_R, 3'd0, -1);
    build(T_LOAD, 3'd2, 0, 3, 1'b0, 0);        run("ld_abort", T_LOAD, 3'd2, 5);
    do_reset("rst_mid_load", 2);

    build(T_LOAD, 3'd2, 2, 3, 1'b0, 0);        run("ld_wait", T_LOAD, 3'd2, -1);
    build(T_BRANCH, 3'd0, 0, 0, 1'b1, 0);      run("beq_z1", T_BRANCH, 3'd0, -1);
    build(T_BRANCH, 3'd1, 0, 0, 1'b1, 0);      run("bne_z1", T_BRANCH, 3'd1, -1);
    build(T_STORE, 3'd2, 0, 0, 1'b0, 0);       run("sw", T_STORE, 3'd2, -1);

    build(7'h7f, 3'd0, 0, 0, 1'b0, 20);        run("ill_op", 7'h7f, 3'd0, -1);
    do_reset("rst_ill_op", 1);
    build(T_BRANCH, 3'b010, 1, 0, 1'b0, 20);   run("ill_f3", T_BRANCH, 3'b010, -1);
    do_reset("rst_ill_f3", 1);

    // Reset arriving in the same cycle as a WB retirement.
    build(T_I, 3'd0, 0, 0, 1'b0, 0);           run("i_pre", T_I, 3'd0, -1);
    build(T_R, 3'd0, 0, 0, 1'b0, 0);           run("r_cut", T_R, 3'd0, 3);
    do_reset("rst_vs_retire", 1);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1: op = T_R;
        2:    op = T_I;
        3, 4: op = T_LOAD;
        5:    op = T_STORE;
        6, 7: op = T_BRANCH;
        default: op = 7'($urandom);
      endcase
      f3 = (op == T_BRANCH && k != 9) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      build(op, f3, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), 4);
      run($sformatf("rnd%0d", n), op, f3, -1);
      if (state == 3'd5 || plan[plan.size()-1].st == 3'd5) do_reset($sformatf("rnd%0d_rst", n), 1);
    end

    @(negedge clk);
    mem_ready = 1'b0;
    force dut.r_retired_count = '1;
    #1;
    release dut.r_retired_count;
    exp_count = 32'hFFFF_FFFF;
    build(T_I, 3'd0, 0, 0, 1'b0, 0);           run("wrap", T_I, 3'd0, -1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("wrap.final_count", retired_count, exp_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
